dual_fetch_queue: RTL and testbench
===================================

Name: dual_fetch_queue

Overview:
- Dual-issue fetch stage that sits directly upstream of the dual-read-port instruction memory.
- Drives both memory read addresses from an internal PC and captures the two returned instruction words.
- Buffers fetched words with their PCs in a small circular queue and presents up to two instructions per cycle to decode.
- Decode consumes from the queue; a redirect from branch resolution flushes it.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word address).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr0  output  32  word address to instruction memory port 0; always equals pc.
- imem_addr1  output  32  word address to instruction memory port 1; always equals pc+1.
- imem_rd0  input  32  instruction word at imem_addr0, combinational, same cycle.
- imem_rd1  input  32  instruction word at imem_addr1, combinational, same cycle.
- redirect_valid  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch word address.
- deq  input  2  number of head entries decode consumes this cycle (0, 1 or 2).
- out_valid0  output  1  head entry valid.
- out_inst0  output  32  head instruction.
- out_pc0  output  32  head PC.
- out_valid1  output  1  second entry valid.
- out_inst1  output  32  second instruction.
- out_pc1  output  32  second PC.
- count  output  clog2(DEPTH)+1  current occupancy, for debug and perf.

Behaviour:
- Addressing is in words, not bytes. imem_addr0 = pc and imem_addr1 = pc+1, both combinational from the pc register.
- PC arithmetic is modulo 2^32; pc = 32'hFFFF_FFFF gives imem_addr1 = 0.

Reset (asynchronous, active-high):
- pc = RESET_PC; head = tail = 0; count = 0.
- All entry pc/inst fields = 0, so out_valid0/1 = 0 and out_inst*/out_pc* = 0.
- Asserting rst mid-operation discards all entries immediately.

Output mapping:
- out_valid0 = (count >= 1); out_valid1 = (count >= 2).
- out_*0 = entry[head]; out_*1 = entry[head+1 mod DEPTH].
- Outputs come straight from registers; no imem-to-decode combinational path.
- When an output is not valid, its inst/pc show stale entry contents. Verification must not check them.

Enqueue:
- Condition: count <= DEPTH-2, evaluated on the pre-dequeue count. A same-cycle deq does not free space for that cycle's enqueue.
- Action: write {pc, imem_rd0} to entry[tail] and {pc+1, imem_rd1} to entry[tail+1]; tail += 2; pc += 2.
- Otherwise (queue full for two entries): pc, tail and entries hold. The memory addresses stay stable, so the fetch is simply re-issued next cycle.

Dequeue:
- eff = min(deq, count); illegal over-dequeue is clamped, never underflows.
- head += eff.
- count_next = count + (enq ? 2 : 0) - eff.

Redirect (highest priority, same clock edge):
- head = tail = 0; count = 0; pc = redirect_pc.
- No enqueue that cycle; deq is ignored.
- The first words at redirect_pc are enqueued on the following edge, so they become visible on out_*0 two edges after redirect is sampled.

Latency and pointers:
- Fetch-to-out_valid0 latency on an empty queue: 1 cycle.
- Steady-state throughput: 2 instructions per cycle when decode drains 2 per cycle, DEPTH >= 4.
- Pointer wrap-around is modulo DEPTH, with clog2(DEPTH) pointer bits.
- Invariant: 0 <= count <= DEPTH at all times.

Decomposition:
- Package fetch_pkg holds:
  - fetch_entry_t struct {pc[31:0], inst[31:0]};
  - the FETCH_WIDTH = 2 constant;
  - NOP_INST = 32'h0000_0000.
- One sub-module, fetch_fifo_2w2r: a circular buffer with 2 writes and 2 reads per cycle, clamped dequeue and a synchronous flush.
- The top level holds the PC register, the enqueue decision, redirect priority and the address outputs.

Test Plan:
- Reset with RESET_PC=0, memory word k = 32'h1000_0000+k, deq=0 -> after reset imem_addr0=0, imem_addr1=1, out_valid0/1=0, count=0. After 1 edge: count=2, out_inst0=32'h1000_0000, out_pc0=0, out_inst1=32'h1000_0001. After 2 edges: count=4, pc=4, then holds.
- Full stall, DEPTH=4, deq=0 for 10 cycles -> count stays 4, imem_addr0 stays 4, head entries unchanged.
- Steady drain, deq=2 every cycle from empty -> after warm-up out_pc0 = 0, 2, 4, ... each cycle; count oscillates within 0..4; no PC skipped or duplicated.
- Redirect while full: redirect_valid=1, redirect_pc=32'h20, deq=2 on the same edge -> next cycle count=0, out_valid0=0, imem_addr0=32'h20. One edge later out_pc0=32'h20, out_pc1=32'h21.
- Over-dequeue with count=1, deq=2 -> count becomes 0 (or 2 if an enqueue happens that edge); no underflow; head advances by 1 only.
- Async reset asserted mid-cycle with count=3 -> out_valid0 drops before the next clock edge, pc=RESET_PC; wrap: redirect_pc=32'hFFFF_FFFF -> imem_addr1=0 and the enqueued out_pc1=0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the dual-issue fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // One queued instruction together with the word address it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instructions fetched per cycle (two memory read ports)
  localparam int unsigned FETCH_WIDTH = 2;

  // Value left in the instruction field of empty entries after reset
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo_2w2r.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo_2w2r
// Description : Circular buffer with two writes and two reads per cycle,
//               clamped dequeue and synchronous flush. Reads are registered
//               entries only, so there is no write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo_2w2r
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  fetch_entry_t             i_wdata0,
  input  fetch_entry_t             i_wdata1,
  input  logic [1:0]               i_deq,
  output fetch_entry_t             o_rdata0,
  output fetch_entry_t             o_rdata1,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_deq_ext;
  logic [CW-1:0]  w_eff;
  logic [CW-1:0]  w_add;

  // Clamp the requested dequeue to the current occupancy so it never underflows
  always_comb begin
    w_deq_ext = CW'(i_deq);
    w_eff     = (w_deq_ext > r_count) ? r_count : w_deq_ext;
    w_add     = i_wr_en ? CW'(FETCH_WIDTH) : '0;
  end

  // Pointer and occupancy update; flush takes priority over read and write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_eff);
      if (i_wr_en) begin
        r_tail <= r_tail + PW'(FETCH_WIDTH);
      end
      r_count <= r_count + w_add - w_eff;
    end
  end

  // Entry storage; a flush only resets the pointers, contents go stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '{pc: 32'h0, inst: NOP_INST};
      end
    end else if (i_wr_en && !i_flush) begin
      r_mem[r_tail]           <= i_wdata0;
      r_mem[r_tail + PW'(1)]  <= i_wdata1;
    end
  end

  assign o_rdata0 = r_mem[r_head];
  assign o_rdata1 = r_mem[r_head + PW'(1)];
  assign o_count  = r_count;

endmodule : fetch_fifo_2w2r
`default_nettype wire

// File: rtl/dual_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : dual_fetch_queue
// Description : Dual-issue fetch stage. Drives two instruction-memory word
//               addresses from the PC, queues returned words with their PCs,
//               and presents up to two instructions per cycle to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_addr0,
  output logic [31:0]              imem_addr1,
  input  logic [31:0]              imem_rd0,
  input  logic [31:0]              imem_rd1,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic [1:0]               deq,
  output logic                     out_valid0,
  output logic [31:0]              out_inst0,
  output logic [31:0]              out_pc0,
  output logic                     out_valid1,
  output logic [31:0]              out_inst1,
  output logic [31:0]              out_pc1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_pc;
  logic          w_enq;
  fetch_entry_t  w_wdata0;
  fetch_entry_t  w_wdata1;
  fetch_entry_t  w_rdata0;
  fetch_entry_t  w_rdata1;
  logic [CW-1:0] w_count;

  // Enqueue only when two slots are free before this cycle's dequeue; a
  // redirect suppresses the fetch because its words belong to the old path
  always_comb begin
    w_enq    = !redirect_valid && (w_count <= CW'(DEPTH - 2));
    w_wdata0 = '{pc: r_pc,          inst: imem_rd0};
    w_wdata1 = '{pc: r_pc + 32'd1,  inst: imem_rd1};
  end

  // PC register: redirect wins, otherwise advance only when the pair was queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_enq) begin
      r_pc <= r_pc + 32'(FETCH_WIDTH);
    end
  end

  fetch_fifo_2w2r #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (redirect_valid),
    .i_wr_en  (w_enq),
    .i_wdata0 (w_wdata0),
    .i_wdata1 (w_wdata1),
    .i_deq    (deq),
    .o_rdata0 (w_rdata0),
    .o_rdata1 (w_rdata1),
    .o_count  (w_count)
  );

  assign imem_addr0 = r_pc;
  assign imem_addr1 = r_pc + 32'd1;
  assign out_valid0 = (w_count != '0);
  assign out_valid1 = (w_count >= CW'(2));
  assign out_inst0  = w_rdata0.inst;
  assign out_pc0    = w_rdata0.pc;
  assign out_inst1  = w_rdata1.inst;
  assign out_pc1    = w_rdata1.pc;
  assign count      = w_count;

endmodule : dual_fetch_queue
`default_nettype wire

// File: tb/tb_dual_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_fetch_queue
// Description : Directed self-checking bench with a scoreboard queue model
//               of the fetch queue contents and PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MEM_BASE = 32'h1000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_entry_t;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr0;
  logic [31:0] imem_addr1;
  logic [31:0] imem_rd0;
  logic [31:0] imem_rd1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  deq;
  logic        out_valid0;
  logic [31:0] out_inst0;
  logic [31:0] out_pc0;
  logic        out_valid1;
  logic [31:0] out_inst1;
  logic [31:0] out_pc1;
  logic [$clog2(DEPTH):0] count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  sb_entry_t   sb[$];
  logic [31:0] m_pc;

  dual_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr0     (imem_addr0),
    .imem_addr1     (imem_addr1),
    .imem_rd0       (imem_rd0),
    .imem_rd1       (imem_rd1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq            (deq),
    .out_valid0     (out_valid0),
    .out_inst0      (out_inst0),
    .out_pc0        (out_pc0),
    .out_valid1     (out_valid1),
    .out_inst1      (out_inst1),
    .out_pc1        (out_pc1),
    .count          (count)
  );

  // Memory model: word k holds MEM_BASE + k
  assign imem_rd0 = MEM_BASE + imem_addr0;
  assign imem_rd1 = MEM_BASE + imem_addr1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every architecturally visible output against the model
  task automatic check_all(input string tag);
    chk({tag, ".count"},  32'(count), 32'(sb.size()));
    chk({tag, ".valid0"}, 32'(out_valid0), 32'(sb.size() >= 1));
    chk({tag, ".valid1"}, 32'(out_valid1), 32'(sb.size() >= 2));
    chk({tag, ".addr0"},  imem_addr0, m_pc);
    chk({tag, ".addr1"},  imem_addr1, m_pc + 32'd1);
    if (sb.size() >= 1) begin
      chk({tag, ".pc0"},   out_pc0,   sb[0].pc);
      chk({tag, ".inst0"}, out_inst0, sb[0].inst);
    end
    if (sb.size() >= 2) begin
      chk({tag, ".pc1"},   out_pc1,   sb[1].pc);
      chk({tag, ".inst1"}, out_inst1, sb[1].inst);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then check
  task automatic step(input string tag, input logic [1:0] d,
                      input logic rv, input logic [31:0] rpc);
    int pre;
    int eff;
    bit enq;
    deq            = d;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
    if (rv) begin
      sb.delete();
      m_pc = rpc;
    end else begin
      pre = sb.size();
      enq = (pre <= int'(DEPTH) - 2);
      eff = (int'(d) > pre) ? pre : int'(d);
      for (int i = 0; i < eff; i++) void'(sb.pop_front());
      if (enq) begin
        sb.push_back('{pc: m_pc,         inst: MEM_BASE + m_pc});
        sb.push_back('{pc: m_pc + 32'd1, inst: MEM_BASE + m_pc + 32'd1});
        m_pc = m_pc + 32'd2;
      end
    end
    deq            = 2'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] last_pc;
    rst            = 1'b1;
    deq            = 2'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    m_pc           = RESET_PC;
    #1;
    // Reset state, including zeroed entry contents
    check_all("reset");
    chk("reset.inst0", out_inst0, 32'h0);
    chk("reset.pc1",   out_pc1,   32'h0);
    #2;
    rst = 1'b0;

    // Fill from reset: two words per edge until full
    step("fill1", 2'd0, 1'b0, 32'h0);
    chk("fill1.inst0_abs", out_inst0, 32'h1000_0000);
    chk("fill1.inst1_abs", out_inst1, 32'h1000_0001);
    step("fill2", 2'd0, 1'b0, 32'h0);
    chk("fill2.pc_abs", imem_addr0, 32'd4);

    // Full stall for 10 cycles
    for (int i = 0; i < 10; i++) step("stall", 2'd0, 1'b0, 32'h0);
    chk("stall.count_abs", 32'(count), 32'd4);

    // Redirect while full, with a same-edge deq that must be ignored
    step("redir", 2'd2, 1'b1, 32'h20);
    chk("redir.addr0_abs", imem_addr0, 32'h20);
    step("redir_fill", 2'd0, 1'b0, 32'h0);
    chk("redir.pc0_abs", out_pc0, 32'h20);
    chk("redir.pc1_abs", out_pc1, 32'h21);

    // Steady drain from empty: out_pc0 must step by 2 every cycle
    step("flush_empty", 2'd0, 1'b1, 32'h0);
    step("drain_warm", 2'd2, 1'b0, 32'h0);
    last_pc = out_pc0;
    for (int i = 0; i < 8; i++) begin
      step("drain", 2'd2, 1'b0, 32'h0);
      chk("drain.seq", out_pc0, last_pc + 32'd2);
      last_pc = out_pc0;
    end

    // Bring to count=1, then over-dequeue
    step("to_full", 2'd0, 1'b0, 32'h0);
    step("deq1", 2'd1, 1'b0, 32'h0);
    step("deq2", 2'd2, 1'b0, 32'h0);
    chk("deq2.count_abs", 32'(count), 32'd1);
    step("overdeq", 2'd2, 1'b0, 32'h0);

    // Build count=3 and hit async reset between edges
    step("refill", 2'd0, 1'b0, 32'h0);
    step("to3", 2'd1, 1'b0, 32'h0);
    chk("to3.count_abs", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    sb.delete();
    m_pc = RESET_PC;
    #1;
    check_all("async_rst");
    #1;
    rst = 1'b0;

    // PC wrap at the top of the address space
    step("wrap_redir", 2'd0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap.addr1_abs", imem_addr1, 32'h0);
    step("wrap_fill", 2'd0, 1'b0, 32'h0);
    chk("wrap.pc1_abs", out_pc1, 32'h0);
    step("wrap_next", 2'd2, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_dual_fetch_queue
`default_nettype wire
